evm_result_reader: RTL and testbench

//  Read-out side of the EVM results interface. After the EVM reports voting_done, it drives

---
 rtl/evm_result_reader_pkg.sv | 30 +++
 rtl/evm_result_reader_if.sv | 22 ++
 rtl/evm_result_reader_rec_hold.sv | 45 ++++
 rtl/evm_result_reader.sv | 207 ++++++++++++++++++++
 tb/tb_evm_result_reader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/evm_result_reader_pkg.sv
// Shared definitions for the EVM result read-out path.
// Covers candidate codes, the display park code and the reader state encoding.
package evm_pkg;

    localparam logic [1:0] CAND_NONE = 2'b00;
    localparam logic [1:0] CAND_1    = 2'b01;
    localparam logic [1:0] CAND_2    = 2'b10;
    localparam logic [1:0] CAND_3    = 2'b11;

    localparam logic [1:0] DISP_PARK = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_EMIT,
        ST_WIN_SELECT,
        ST_WIN_SETTLE,
        ST_WIN_CAPTURE,
        ST_WIN_EMIT,
        ST_DONE,
        ST_ERROR
    } rd_state_e;

    function automatic logic is_busy(rd_state_e s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
    endfunction

endpackage

// File: rtl/evm_result_reader_if.sv
// Record stream from the result reader toward the display/logging path.
interface evm_result_reader_if #(
    parameter int WIDTH = 7
);
    logic             rec_valid;
    logic             rec_ready;
    logic [1:0]       rec_name;
    logic [WIDTH-1:0] rec_count;
    logic             rec_is_winner;
    logic             rec_tie;
    logic             rec_last;

    modport master (
        output rec_valid, rec_name, rec_count, rec_is_winner, rec_tie, rec_last,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_name, rec_count, rec_is_winner, rec_tie, rec_last,
        output rec_ready
    );
endinterface

// File: rtl/evm_result_reader_rec_hold.sv
// Valid/ready output register: loads one record, holds it until accepted, flushes on abort.
module evm_rec_hold #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic             ready,
    input  logic [1:0]       name_in,
    input  logic [WIDTH-1:0] count_in,
    input  logic             win_in,
    input  logic             tie_in,
    input  logic             last_in,
    output logic             valid,
    output logic [1:0]       name,
    output logic [WIDTH-1:0] count,
    output logic             is_winner,
    output logic             tie,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= 1'b0;
            name      <= '0;
            count     <= '0;
            is_winner <= 1'b0;
            tie       <= 1'b0;
            last      <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid     <= 1'b1;
            name      <= name_in;
            count     <= count_in;
            is_winner <= win_in;
            tie       <= tie_in;
            last      <= last_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/evm_result_reader.sv
// Steps the EVM display selects through the three tallies and the winner and
// streams one record per step; guards against name/count inconsistencies.
module evm_result_reader
    import evm_pkg::*;
#(
    parameter int WIDTH         = 7,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_readout,
    input  logic                voting_done,
    input  logic                invalid_results,
    input  logic [1:0]          candidate_name,
    input  logic [WIDTH-1:0]    results,
    output logic [1:0]          display_results,
    output logic                display_winner,
    evm_result_reader_if.master rec,
    output logic [WIDTH+1:0]    total_votes,
    output logic                readout_busy,
    output logic                readout_done,
    output logic                readout_error
);

    rd_state_e        state;
    logic [1:0]       k;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] cnt_store [3];
    logic [WIDTH-1:0] stored_sel;

    logic             flush, ld, tie_cap, name_ok, win_ok;
    logic [1:0]       ld_name;
    logic [WIDTH-1:0] ld_count;
    logic             ld_win, ld_tie, ld_last;

    always_comb begin
        case (candidate_name)
            CAND_1:  stored_sel = cnt_store[0];
            CAND_2:  stored_sel = cnt_store[1];
            CAND_3:  stored_sel = cnt_store[2];
            default: stored_sel = '0;
        endcase
    end

    // A tie is only reported on the first step; it ends the readout with one record.
    always_comb begin
        flush    = is_busy(state) && !voting_done;
        tie_cap  = (k == 2'd0) && invalid_results;
        name_ok  = (candidate_name == (k + CAND_1));
        win_ok   = (candidate_name != CAND_NONE) && (results == stored_sel);
        ld       = 1'b0;
        ld_name  = CAND_NONE;
        ld_count = '0;
        ld_win   = 1'b0;
        ld_tie   = 1'b0;
        ld_last  = 1'b0;
        if (!flush) begin
            case (state)
                ST_CAPTURE: begin
                    if (tie_cap) begin
                        ld      = 1'b1;
                        ld_tie  = 1'b1;
                        ld_last = 1'b1;
                    end else if (name_ok) begin
                        ld       = 1'b1;
                        ld_name  = candidate_name;
                        ld_count = results;
                    end
                end
                ST_WIN_CAPTURE: begin
                    if (win_ok) begin
                        ld       = 1'b1;
                        ld_name  = candidate_name;
                        ld_count = results;
                        ld_win   = 1'b1;
                        ld_last  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE && !flush && !tie_cap && name_ok)
            cnt_store[k] <= results;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            k               <= 2'd0;
            settle_cnt      <= 4'd0;
            total_votes     <= '0;
            display_results <= DISP_PARK;
            display_winner  <= 1'b0;
        end else if (flush) begin
            state           <= ST_ERROR;
            display_results <= DISP_PARK;
            display_winner  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_readout && voting_done) begin
                        state       <= ST_SELECT;
                        k           <= 2'd0;
                        total_votes <= '0;
                    end
                end
                ST_SELECT: begin
                    display_results <= k;
                    display_winner  <= 1'b0;
                    settle_cnt      <= 4'(SETTLE_CYCLES);
                    state           <= ST_SETTLE;
                end
                ST_SETTLE, ST_WIN_SETTLE: begin
                    if (settle_cnt != 4'd0)
                        settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1)
                        state <= (state == ST_SETTLE) ? ST_CAPTURE : ST_WIN_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (tie_cap) begin
                        state <= ST_EMIT;
                    end else if (name_ok) begin
                        total_votes <= total_votes + (WIDTH+2)'(results);
                        state       <= ST_EMIT;
                    end else begin
                        state           <= ST_ERROR;
                        display_results <= DISP_PARK;
                    end
                end
                ST_EMIT: begin
                    if (rec.rec_valid && rec.rec_ready) begin
                        if (rec.rec_last) begin
                            state           <= ST_DONE;
                            display_results <= DISP_PARK;
                        end else if (k == 2'd2) begin
                            state <= ST_WIN_SELECT;
                        end else begin
                            k     <= k + 2'd1;
                            state <= ST_SELECT;
                        end
                    end
                end
                ST_WIN_SELECT: begin
                    display_winner  <= 1'b1;
                    display_results <= DISP_PARK;
                    settle_cnt      <= 4'(SETTLE_CYCLES);
                    state           <= ST_WIN_SETTLE;
                end
                ST_WIN_CAPTURE: begin
                    if (win_ok) begin
                        state <= ST_WIN_EMIT;
                    end else begin
                        state          <= ST_ERROR;
                        display_winner <= 1'b0;
                    end
                end
                ST_WIN_EMIT: begin
                    if (rec.rec_valid && rec.rec_ready) begin
                        state          <= ST_DONE;
                        display_winner <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!voting_done) begin
                        state <= ST_IDLE;
                    end else if (start_readout) begin
                        state       <= ST_SELECT;
                        k           <= 2'd0;
                        total_votes <= '0;
                    end
                end
                ST_ERROR: begin
                    if (!voting_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign readout_busy  = is_busy(state);
    assign readout_done  = (state == ST_DONE);
    assign readout_error = (state == ST_ERROR);

    evm_rec_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .flush     (flush),
        .ready     (rec.rec_ready),
        .name_in   (ld_name),
        .count_in  (ld_count),
        .win_in    (ld_win),
        .tie_in    (ld_tie),
        .last_in   (ld_last),
        .valid     (rec.rec_valid),
        .name      (rec.rec_name),
        .count     (rec.rec_count),
        .is_winner (rec.rec_is_winner),
        .tie       (rec.rec_tie),
        .last      (rec.rec_last)
    );

endmodule

// File: tb/tb_evm_result_reader.sv
// Bench for evm_result_reader: behavioural EVM plus a record-list reference model.
module tb_evm_result_reader;
    import evm_pkg::*;

    localparam int W = 7;

    typedef struct packed {
        logic [1:0]   name;
        logic [W-1:0] count;
        logic         win;
        logic         tie;
        logic         last;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_readout;
    logic           voting_done;
    logic           invalid_results;
    logic [1:0]     candidate_name;
    logic [W-1:0]   results;
    logic [1:0]     display_results;
    logic           display_winner;
    logic [W+1:0]   total_votes;
    logic           readout_busy;
    logic           readout_done;
    logic           readout_error;

    logic [W-1:0]   votes [3];
    logic           bad_name;
    int             win_idx;
    logic           is_tie;
    logic           win_seen;
    rec_t           got_q [$];
    rec_t           exp_q [$];

    int             checks = 0;
    int             errors = 0;

    evm_result_reader_if #(.WIDTH(W)) rec_if ();

    evm_result_reader #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_readout   (start_readout),
        .voting_done     (voting_done),
        .invalid_results (invalid_results),
        .candidate_name  (candidate_name),
        .results         (results),
        .display_results (display_results),
        .display_winner  (display_winner),
        .rec             (rec_if),
        .total_votes     (total_votes),
        .readout_busy    (readout_busy),
        .readout_done    (readout_done),
        .readout_error   (readout_error)
    );

    always #5 clk = ~clk;

    // Winner is the unique maximum; a shared maximum is a tie.
    always_comb begin
        int m;
        int n;
        m = 0;
        n = 0;
        win_idx = 0;
        for (int i = 0; i < 3; i++) if (int'(votes[i]) > m) m = int'(votes[i]);
        for (int i = 2; i >= 0; i--) if (int'(votes[i]) == m) begin n++; win_idx = i; end
        is_tie = (n > 1);
    end

    // EVM side: answers the display selects combinationally.
    always_comb begin
        results         = '0;
        candidate_name  = 2'b00;
        invalid_results = is_tie;
        if (display_winner) begin
            results        = votes[win_idx];
            candidate_name = 2'(win_idx + 1);
        end else if (display_results != 2'b11) begin
            results        = votes[display_results];
            candidate_name = (bad_name && display_results == 2'b00) ? 2'b10 : display_results + 2'd1;
        end
    end

    always @(negedge clk) begin
        if (rst && rec_if.rec_valid && rec_if.rec_ready)
            got_q.push_back({rec_if.rec_name, rec_if.rec_count, rec_if.rec_is_winner,
                             rec_if.rec_tie, rec_if.rec_last});
        if (display_winner) win_seen <= 1'b1;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_votes(input int a, input int b, input int c);
        votes[0] = W'(a);
        votes[1] = W'(b);
        votes[2] = W'(c);
    endtask

    function automatic int exp_total();
        return is_tie ? 0 : int'(votes[0]) + int'(votes[1]) + int'(votes[2]);
    endfunction

    task automatic compare_records(input string tag);
        rec_t r;
        exp_q.delete();
        if (is_tie) begin
            r = '{name: 2'b00, count: '0, win: 1'b0, tie: 1'b1, last: 1'b1};
            exp_q.push_back(r);
        end else begin
            for (int i = 0; i < 3; i++) begin
                r = '{name: 2'(i + 1), count: votes[i], win: 1'b0, tie: 1'b0, last: 1'b0};
                exp_q.push_back(r);
            end
            r = '{name: 2'(win_idx + 1), count: votes[win_idx], win: 1'b1, tie: 1'b0, last: 1'b1};
            exp_q.push_back(r);
        end
        chk({tag, "_nrec"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_rec%0d", tag, i), longint'(got_q[i]), longint'(exp_q[i]));
    endtask

    task automatic run_readout(input bit rnd_ready, output int lat, output int dcyc);
        lat  = -1;
        dcyc = -1;
        start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (lat < 0 && rec_if.rec_valid) lat = n;
            if (readout_done) begin dcyc = n; break; end
            if (rnd_ready) rec_if.rec_ready = 1'($urandom_range(0, 1));
        end
        rec_if.rec_ready = rec_if.rec_ready | ~rnd_ready;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!rec_if.rec_valid && n < 30) begin @(posedge clk); #1; n++; end
        chk({tag, "_valid_seen"}, rec_if.rec_valid, 1);
    endtask

    task automatic end_session(input string tag);
        voting_done = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_done"}, readout_done, 0);
        chk({tag, "_idle_busy"}, readout_busy, 0);
    endtask

    initial begin
        int lat, dcyc, n;
        rst = 1'b0; start_readout = 1'b0; voting_done = 1'b0; bad_name = 1'b0;
        rec_if.rec_ready = 1'b0; win_seen = 1'b0;
        set_votes(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rec_if.rec_valid, 0);
        chk("rst_disp", display_results, 3);
        chk("rst_winsel", display_winner, 0);
        chk("rst_busy", readout_busy, 0);
        chk("rst_done", readout_done, 0);
        chk("rst_err", readout_error, 0);
        chk("rst_total", total_votes, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // start without voting_done is ignored
        start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
        @(posedge clk); #1;
        chk("nostart_busy", readout_busy, 0);

        // basic readout 5/3/2
        set_votes(5, 3, 2); voting_done = 1'b1; rec_if.rec_ready = 1'b1; got_q.delete();
        run_readout(1'b0, lat, dcyc);
        chk("t1_latency", lat, 3);
        chk("t1_done_in_16", (dcyc > 0 && dcyc <= 16), 1);
        compare_records("t1");
        chk("t1_total", total_votes, 10);
        chk("t1_busy", readout_busy, 0);

        // restart directly from DONE
        got_q.delete();
        run_readout(1'b0, lat, dcyc);
        chk("restart_done", dcyc > 0, 1);
        compare_records("restart");
        end_session("t1");

        // tie 4/4/1
        set_votes(4, 4, 1); voting_done = 1'b1; got_q.delete(); win_seen = 1'b0;
        run_readout(1'b0, lat, dcyc);
        chk("t2_done", dcyc > 0, 1);
        compare_records("t2");
        chk("t2_no_winsel", win_seen, 0);
        end_session("t2");

        // back-pressure on record 2
        set_votes(6, 2, 1); voting_done = 1'b1; rec_if.rec_ready = 1'b0; got_q.delete();
        start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
        wait_valid("t3a");
        rec_if.rec_ready = 1'b1;
        @(posedge clk); #1;
        rec_if.rec_ready = 1'b0;
        @(posedge clk); #1;
        wait_valid("t3b");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", rec_if.rec_valid, 1);
            chk("t3_hold_name", rec_if.rec_name, 2);
            chk("t3_hold_count", rec_if.rec_count, 2);
            chk("t3_hold_disp", display_results, 1);
        end
        @(posedge clk); #1;
        rec_if.rec_ready = 1'b1;
        n = 0;
        while (!readout_done && n < 40) begin @(posedge clk); #1; n++; end
        chk("t3_done", readout_done, 1);
        compare_records("t3");
        chk("t3_total", total_votes, 9);
        end_session("t3");

        // boundary counts
        set_votes(127, 126, 125); voting_done = 1'b1; got_q.delete();
        run_readout(1'b0, lat, dcyc);
        compare_records("max");
        chk("max_total", total_votes, 378);
        end_session("max");

        // randomized rounds with random back-pressure
        for (int r = 0; r < 10; r++) begin
            set_votes(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 127)));
            if (r == 3) set_votes(50, 50, 90);
            voting_done = 1'b1; got_q.delete();
            run_readout(1'b1, lat, dcyc);
            chk($sformatf("rnd%0d_done", r), dcyc > 0, 1);
            compare_records($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_total", r), total_votes, exp_total());
            end_session($sformatf("rnd%0d", r));
        end
        rec_if.rec_ready = 1'b1;

        // voting_done drops during SETTLE of k=1
        set_votes(3, 2, 1); voting_done = 1'b1; got_q.delete();
        start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
        n = 0;
        while (display_results != 2'b01 && n < 30) begin @(posedge clk); #1; n++; end
        chk("t4_reach_k1", display_results, 1);
        voting_done = 1'b0;
        @(posedge clk); #1;
        chk("t4_err", readout_error, 1);
        chk("t4_valid", rec_if.rec_valid, 0);
        chk("t4_busy", readout_busy, 0);
        @(posedge clk); #1;
        chk("t4_err_clr", readout_error, 0);
        chk("t4_idle_busy", readout_busy, 0);
        chk("t4_nrec", got_q.size(), 1);

        // wrong candidate name on select 00
        bad_name = 1'b1; voting_done = 1'b1; got_q.delete();
        start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
        n = 0;
        while (!readout_error && n < 20) begin @(posedge clk); #1; n++; end
        chk("t5_err", readout_error, 1);
        chk("t5_valid", rec_if.rec_valid, 0);
        @(posedge clk); #1;
        chk("t5_err_sticky", readout_error, 1);
        chk("t5_nrec", got_q.size(), 0);
        voting_done = 1'b0;
        @(posedge clk); #1;
        chk("t5_err_clr", readout_error, 0);
        bad_name = 1'b0;

        // asynchronous reset while a record waits
        set_votes(7, 8, 9); voting_done = 1'b1; rec_if.rec_ready = 1'b0; got_q.delete();
        start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
        wait_valid("t6");
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", rec_if.rec_valid, 0);
        chk("t6_name", rec_if.rec_name, 0);
        chk("t6_count", rec_if.rec_count, 0);
        chk("t6_disp", display_results, 3);
        chk("t6_winsel", display_winner, 0);
        chk("t6_busy", readout_busy, 0);
        chk("t6_total", total_votes, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        got_q.delete();
        rec_if.rec_ready = 1'b1;
        run_readout(1'b0, lat, dcyc);
        chk("t6_done", dcyc > 0, 1);
        compare_records("t6");
        chk("t6_total2", total_votes, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
